// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : funct3 codes, write-strobe encodings and FSM states for the LSU.
//  Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [2:0] c_STRB_WORD = 3'b000;
    localparam logic [2:0] c_STRB_LO   = 3'b001;
    localparam logic [2:0] c_STRB_NOP  = 3'b010;
    localparam logic [2:0] c_STRB_HI   = 3'b011;
    localparam logic       c_STRB_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        BYTE   = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == c_F3_B) || (f3 == c_F3_H) || (f3 == c_F3_W);
        else    ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        return ok;
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    // Index of the final byte of a byte-serial access (halfword or word).
    function automatic logic [1:0] f3_last_byte(input logic [2:0] f3);
        return f3[1] ? 2'd3 : 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Purpose  : selects the loaded byte/halfword at an offset and extends it.
//  Revision : 1.0
// ============================================================================
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = raw_i[{offset_i, 3'b000} +: 8];
        w_half = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (funct3_i)
            c_F3_B:  data_o = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: data_o = {24'h0, w_byte};
            c_F3_H:  data_o = {{16{w_half[15]}}, w_half};
            c_F3_HU: data_o = {16'h0, w_half};
            default: data_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : single-outstanding RISC-V load/store unit; misaligned accesses
//             are split into byte-serial cycles.  Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [31:0]   mem_rd_data,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_din,
    output logic          mem_we,
    output logic [2:0]    mem_wr_strb
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic [31:0] w_cur_addr;
    logic [31:0] w_load_data;
    logic        w_req_legal;
    logic        w_unused_addr;

    // k_q stays 0 outside BYTE, so this is the access address in every state.
    assign w_cur_addr    = addr_q + {30'h0, k_q};
    assign w_unused_addr = ^w_cur_addr[31:AW+2];
    assign w_req_legal   = f3_legal(req_we, req_funct3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            k_q      <= 2'd0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            k_q      <= k_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        k_d      = k_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    k_d      = 2'd0;
                    rdata_d  = 32'h0;
                    err_d    = ~w_req_legal;
                    mis_d    = w_req_legal && !f3_aligned(req_funct3, req_addr[1:0]);
                    if (!w_req_legal)
                        state_d = RESP;
                    else if (f3_aligned(req_funct3, req_addr[1:0]))
                        state_d = ACCESS;
                    else
                        state_d = BYTE;
                end
            end
            ACCESS: begin
                if (!we_q) rdata_d = mem_rd_data;
                state_d = RESP;
            end
            BYTE: begin
                if (!we_q)
                    rdata_d[{k_q, 3'b000} +: 8] = mem_rd_data[{w_cur_addr[1:0], 3'b000} +: 8];
                if (k_q == f3_last_byte(funct3_q)) begin
                    k_d     = 2'd0;
                    state_d = RESP;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port; rst suppresses the write at the edge that aborts a request.
    always_comb begin
        mem_we      = 1'b0;
        mem_wr_strb = c_STRB_NOP;
        mem_wr_din  = 32'h0;
        mem_rd_addr = (state_q == IDLE) ? '0 : w_cur_addr[AW+1:2];
        mem_wr_addr = mem_rd_addr;
        if (we_q && !err_q && !rst) begin
            if (state_q == ACCESS) begin
                mem_we = 1'b1;
                case (funct3_q[1:0])
                    2'b10: begin
                        mem_wr_strb = c_STRB_WORD;
                        mem_wr_din  = wdata_q;
                    end
                    2'b01: begin
                        mem_wr_strb = addr_q[1] ? c_STRB_HI : c_STRB_LO;
                        mem_wr_din  = {16'h0, wdata_q[15:0]};
                    end
                    default: begin
                        mem_wr_strb = {c_STRB_BYTE, addr_q[1:0]};
                        mem_wr_din  = {24'h0, wdata_q[7:0]};
                    end
                endcase
            end else if (state_q == BYTE) begin
                mem_we      = 1'b1;
                mem_wr_strb = {c_STRB_BYTE, w_cur_addr[1:0]};
                mem_wr_din  = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
            end
        end
    end

    // Misaligned loads are already assembled LSB-first, so extract at offset 0.
    load_align u_load_align (
        .raw_i    (rdata_q),
        .funct3_i (funct3_q),
        .offset_i (mis_q ? 2'b00 : addr_q[1:0]),
        .data_o   (w_load_data)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? w_load_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : directed stimulus against a byte-array reference of the LSU.
//  Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int DEPTH  = 128;
    localparam int AW     = $clog2(DEPTH);
    localparam int NBYTES = DEPTH * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_din;
    logic          mem_we;
    logic [2:0]    mem_wr_strb;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit mem_clr = 1'b1;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_din  (mem_wr_din),
        .mem_we      (mem_we),
        .mem_wr_strb (mem_wr_strb)
    );

    // Data memory attached to the DUT.
    logic [31:0] dmem [DEPTH];
    assign mem_rd_data = dmem[mem_rd_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= 32'h0;
        end else if (mem_we) begin
            case (mem_wr_strb)
                3'b000:  dmem[mem_wr_addr] <= mem_wr_din;
                3'b001:  dmem[mem_wr_addr][15:0] <= mem_wr_din[15:0];
                3'b011:  dmem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
                3'b100, 3'b101, 3'b110, 3'b111:
                    dmem[mem_wr_addr][{mem_wr_strb[1:0], 3'b000} +: 8] <= mem_wr_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flat byte memory plus the current request in flight.
    logic [7:0]  refmem [NBYTES];
    bit          m_busy = 1'b0;
    int          m_cyc = 0;
    int          m_lat = 0;
    int          m_size = 1;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic        m_mis = 1'b0;
    logic [2:0]  m_f3 = 3'b000;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    function automatic int bidx(input logic [31:0] a);
        return int'(a & (NBYTES - 1));
    endfunction

    always @(posedge clk) begin
        if (mem_clr)
            for (int i = 0; i < NBYTES; i++) refmem[i] = 8'h00;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_we && !m_err && m_cyc < m_lat) begin
                if (m_mis)
                    refmem[bidx(m_addr + 32'(m_cyc - 1))] = m_wdata[8*(m_cyc-1) +: 8];
                else
                    for (int k = 0; k < m_size; k++)
                        refmem[bidx(m_addr + 32'(k))] = m_wdata[8*k +: 8];
            end
            if (m_cyc == m_lat) m_busy = 1'b0;
            else                m_cyc++;
        end else if (req_valid) begin
            m_we    = req_we;
            m_f3    = req_funct3;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_size  = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
            m_err   = req_we ? (req_funct3 > 3'd2)
                             : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
            m_mis   = !m_err && ((req_addr % 32'(m_size)) != 0);
            m_lat   = m_err ? 1 : (m_mis ? m_size + 1 : 2);
            m_rdata = 32'h0;
            if (!m_we && !m_err) begin
                for (int k = 0; k < m_size; k++)
                    m_rdata[8*k +: 8] = refmem[bidx(req_addr + 32'(k))];
                if (req_funct3 == 3'b000) m_rdata = {{24{m_rdata[7]}}, m_rdata[7:0]};
                if (req_funct3 == 3'b001) m_rdata = {{16{m_rdata[15]}}, m_rdata[15:0]};
            end
            m_busy = 1'b1;
            m_cyc  = 1;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic        acc;
        logic        exp_wr;
        logic [31:0] b;
        logic [31:0] mask;
        logic [31:0] ed;
        logic [2:0]  es;
        if (chk_en) begin
            acc    = m_busy && !m_err && (m_cyc < m_lat);
            exp_wr = acc && m_we && !rst;
            b      = m_mis ? m_addr + 32'(m_cyc - 1) : m_addr;
            chk("req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, m_busy && (m_cyc == m_lat)});
            if (m_busy && m_cyc == m_lat) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, m_err});
            end
            chk("mem_we", {31'h0, mem_we}, {31'h0, exp_wr});
            if (acc)
                chk("mem_rd_addr", 32'(mem_rd_addr), (b >> 2) % DEPTH);
            if (!m_busy) begin
                chk("mem_rd_addr_idle", 32'(mem_rd_addr), 32'h0);
                chk("mem_wr_addr_idle", 32'(mem_wr_addr), 32'h0);
            end
            if (exp_wr) begin
                if (m_mis) begin
                    es   = {1'b1, b[1:0]};
                    mask = 32'h0000_00FF;
                    ed   = {24'h0, m_wdata[8*(m_cyc-1) +: 8]};
                end else if (m_size == 4) begin
                    es = 3'b000; mask = 32'hFFFF_FFFF; ed = m_wdata;
                end else if (m_size == 2) begin
                    es = m_addr[1] ? 3'b011 : 3'b001; mask = 32'h0000_FFFF; ed = m_wdata & mask;
                end else begin
                    es = {1'b1, m_addr[1:0]}; mask = 32'h0000_00FF; ed = m_wdata & mask;
                end
                chk("mem_wr_addr", 32'(mem_wr_addr), (b >> 2) % DEPTH);
                chk("mem_wr_strb", {29'h0, mem_wr_strb}, {29'h0, es});
                chk("mem_wr_din", mem_wr_din & mask, ed);
            end else begin
                chk("mem_wr_strb_nop", {29'h0, mem_wr_strb}, 32'h2);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rd, output logic er, output int lat);
        bit seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (hold) begin
            req_addr = 32'h0000_0040; req_wdata = 32'h5555_5555; req_we = 1'b1;
        end else begin
            req_valid = 1'b0;
        end
        seen = 1'b0; rd = 32'h0; er = 1'b0; lat = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1; lat = n; rd = resp_rdata; er = resp_err;
            end else if (hold && n == 1) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (!seen) begin
            n_chk++; n_err++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
        end
        @(posedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen_rv;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_wr_strb", {29'h0, mem_wr_strb}, 32'h2);
        chk("rst_addrs", 32'(mem_rd_addr) | 32'(mem_wr_addr), 32'h0);
        chk("rst_mem_wr_din", mem_wr_din, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0; chk_en = 1'b1;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_word4", dmem[4], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_lat", 32'(lat), 32'd2);

        do_req(1'b1, 3'b000, 32'h13, 32'h80, 1'b0, rd, er, lat);
        chk("sb_word4", dmem[4], 32'h80ADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("lb_data", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("lbu_data", rd, 32'h00000080);

        do_req(1'b1, 3'b010, 32'h05, 32'h11223344, 1'b0, rd, er, lat);
        chk("msw_lat", 32'(lat), 32'd5);
        chk("msw_word1", dmem[1], 32'h22334400);
        chk("msw_word2", dmem[2], 32'h00000011);
        do_req(1'b0, 3'b010, 32'h05, 32'h0, 1'b0, rd, er, lat);
        chk("mlw_data", rd, 32'h11223344);
        chk("mlw_lat", 32'(lat), 32'd5);

        do_req(1'b1, 3'b000, 32'h03, 32'h34, 1'b0, rd, er, lat);
        do_req(1'b1, 3'b000, 32'h04, 32'h92, 1'b0, rd, er, lat);
        do_req(1'b0, 3'b001, 32'h03, 32'h0, 1'b0, rd, er, lat);
        chk("mlh_data", rd, 32'hFFFF9234);
        chk("mlh_lat", 32'(lat), 32'd3);
        do_req(1'b0, 3'b101, 32'h03, 32'h0, 1'b0, rd, er, lat);
        chk("mlhu_data", rd, 32'h00009234);

        do_req(1'b0, 3'b011, 32'h00, 32'h0, 1'b0, rd, er, lat);
        chk("ill_ld_err", {31'h0, er}, 32'h1);
        chk("ill_ld_rdata", rd, 32'h0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        do_req(1'b1, 3'b101, 32'h10, 32'hFFFFFFFF, 1'b0, rd, er, lat);
        chk("ill_st_err", {31'h0, er}, 32'h1);

        // Request held valid while busy must be ignored.
        do_req(1'b1, 3'b001, 32'h0E, 32'h00001234, 1'b1, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, rd, er, lat);
        chk("sh_hi_word3", rd, 32'h12340000);
        chk("held_req_ignored", dmem[16], 32'h0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, er, lat);
        chk("lh_hi_data", rd, 32'hFFFF80AD);
        do_req(1'b0, 3'b010, 32'h80000010, 32'h0, 1'b0, rd, er, lat);
        chk("lw_highbits", rd, 32'h80ADBEEF);

        do_req(1'b1, 3'b010, 32'h1FE, 32'hCAFEF00D, 1'b0, rd, er, lat);
        chk("wrap_word127_hi", {16'h0, dmem[127][31:16]}, 32'h0000F00D);
        chk("wrap_word0_lo", {16'h0, dmem[0][15:0]}, 32'h0000CAFE);
        do_req(1'b0, 3'b010, 32'h1FE, 32'h0, 1'b0, rd, er, lat);
        chk("wrap_lw", rd, 32'hCAFEF00D);
        do_req(1'b0, 3'b001, 32'h01, 32'h0, 1'b0, rd, er, lat);

        // Abort a misaligned store during its third byte cycle.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h21; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_rv = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen_rv = 1'b1;
        end
        chk("abort_no_resp", {31'h0, seen_rv}, 32'h0);
        chk("abort_word8", dmem[8], 32'h00CCDD00);
        chk("abort_word9", dmem[9], 32'h0);

        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("after_abort_lw", rd, 32'h00CCDD00);

        for (int w = 0; w < DEPTH; w++)
            chk($sformatf("mem_word%0d", w), dmem[w],
                {refmem[4*w+3], refmem[4*w+2], refmem[4*w+1], refmem[4*w]});

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 128, number of 32-bit data-memory words; AW = $clog2(DEPTH).
REQ-002 SHALL have ports (name  direction  width  meaning), in this order:
  clk  in  1  single clock, rising edge.
  rst  in  1  reset, synchronous, active-high.
  req_valid  in  1  core presents a load/store.
  req_ready  out  1  unit can accept a request.
  req_we  in  1  1 = store, 0 = load.
  req_funct3  in  3  RISC-V funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
  req_addr  in  32  byte address.
  req_wdata  in  32  store data, LSB-aligned.
  resp_valid  out  1  one-cycle completion pulse.
  resp_rdata  out  32  extended load data; 0 for stores and errors.
  resp_err  out  1  illegal funct3, valid with resp_valid.
  mem_rd_addr  out  AW  word address to data memory read port.
  mem_rd_data  in  32  asynchronous read data from data memory.
  mem_wr_addr  out  AW  word address to data memory write port.
  mem_wr_din  out  32  write data, LSB-aligned.
  mem_we  out  1  write enable.
  mem_wr_strb  out  3  000 word, 001 low half, 010 nop, 011 high half, 1bb byte bb.

Function
REQ-003 SHALL implement states IDLE, ACCESS, BYTE, RESP; req_ready = 1 only in IDLE.
REQ-004 SHALL register req_we, req_funct3, req_addr, req_wdata on req_valid && req_ready, then move to ACCESS (aligned), BYTE (misaligned) or RESP (illegal).
REQ-005 SHALL treat as aligned: byte ops; halfword with addr[1:0] in {0,2}; word with addr[1:0] = 0. All else misaligned.
REQ-006 SHALL form word address as addr[AW+1:2]; higher address bits ignored, wrapping modulo DEPTH.
REQ-007 ACCESS SHALL last exactly one cycle: stores drive mem_we = 1 with strb 000 (SW), 001/011 (SH offset 0/2), 100+offset (SB), data in mem_wr_din[7:0]/[15:0]/[31:0]; loads sample mem_rd_data into the result register at end of cycle.
REQ-008 BYTE SHALL iterate k = 0..size-1 (2 or 4), one cycle per byte, at byte address addr+k (32-bit add, wraps), strb 100+((addr+k)&3), data req_wdata byte k; loads place byte k into result bits [8k+7:8k].
REQ-009 SHALL go to RESP after the last ACCESS/BYTE cycle; RESP lasts one cycle with resp_valid = 1, then IDLE.
REQ-010 Load extraction: LB/LBU selects byte at offset, LH/LHU halfword at offset[1]; LB/LH sign-extend, LBU/LHU zero-extend; misaligned loads assemble then extend identically.
REQ-011 Illegal: loads funct3 011/110/111, stores funct3 not in {000,001,010}; SHALL perform no memory access, resp_err = 1, resp_rdata = 0.
REQ-012 Outside ACCESS/BYTE stores: mem_we = 0, mem_wr_strb = 010; mem_rd_addr/mem_wr_addr SHALL always reflect the current access word (0 in IDLE).
REQ-013 Latency from accept edge to resp_valid: aligned 2 cycles, misaligned halfword 3, misaligned word 5, illegal 1.
REQ-014 req_valid outside IDLE SHALL be ignored; no request queuing.

Reset
REQ-015 rst high at a clock edge SHALL force IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_wr_strb = 010, addresses 0, mem_wr_din = 0, internal registers 0.
REQ-016 rst mid-operation SHALL abort; writes already committed remain, no further writes, no resp_valid for the aborted request.

Structure
REQ-017 Shared package lsu_pkg SHALL hold funct3 constants, mem_wr_strb encodings and the state enum.
REQ-018 Load extract/extend SHALL be a combinational sub-module load_align.

Verification
REQ-019 SW 0xDEADBEEF @0x10 then LW @0x10 -> mem word 4 = 0xDEADBEEF, resp_rdata 0xDEADBEEF, 2-cycle latency each.
REQ-020 SB 0x80 @0x13, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; strb 111 on store.
REQ-021 SW 0x11223344 @0x05 -> byte writes strb 101,110,111 to word 1, then 100 to word 2; LW @0x05 -> 0x11223344, latency 5.
REQ-022 LH @0x03 with bytes 0x34@3, 0x92@4 -> 0xFFFF9234, latency 3; LHU -> 0x00009234.
REQ-023 funct3 011 load -> resp_err 1, resp_rdata 0, mem_we never asserted, latency 1.
REQ-024 rst asserted during 3rd cycle of misaligned SW -> IDLE next cycle, only first two bytes written, no resp_valid.
